// File: rtl/jedro_1_csr_pkg.sv
// Shared types and constants for the jedro_1 CSR access controller.
// Holds the funct3 op encodings, controller states and well-known CSR addresses.
package jedro_1_csr_pkg;

    typedef enum logic [2:0] {
        OP_RSV0 = 3'b000,
        OP_RW   = 3'b001,
        OP_RS   = 3'b010,
        OP_RC   = 3'b011,
        OP_RSV4 = 3'b100,
        OP_RWI  = 3'b101,
        OP_RSI  = 3'b110,
        OP_RCI  = 3'b111
    } csr_op_e;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_READ    = 2'd1,
        ST_WRITE   = 2'd2,
        ST_TRAP_WR = 2'd3
    } ctrl_state_e;

    localparam logic [11:0] CSR_MSCRATCH = 12'h340;
    localparam logic [11:0] CSR_MEPC     = 12'h341;
    localparam logic [11:0] CSR_MCAUSE   = 12'h342;
    localparam logic [1:0]  RO_PREFIX    = 2'b11;

    // RS/RC variants with a zero source only read the CSR.
    function automatic logic op_write_en(csr_op_e op, logic src_zero);
        logic wen;
        wen = 1'b0;
        case (op)
            OP_RW, OP_RWI:                        wen = 1'b1;
            OP_RS, OP_RSI, OP_RC, OP_RCI:         wen = !src_zero;
            default:                              wen = 1'b0;
        endcase
        return wen;
    endfunction

    function automatic logic op_reserved(csr_op_e op);
        return (op == OP_RSV0) || (op == OP_RSV4);
    endfunction

endpackage

// File: rtl/jedro_1_csr_rr_arb.sv
// Two-way round-robin arbiter; req[1]/gnt[1] is the trap port, index 0 the instruction port.
// last_q remembers which index won most recently (0 after reset, so index 1 wins first).
module jedro_1_csr_rr_arb (
    input  logic       clk_i,
    input  logic       rstn_i,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] gnt
);

    logic last_q;

    always_comb begin
        gnt = req;
        if (req == 2'b11) begin
            gnt = last_q ? 2'b01 : 2'b10;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            last_q <= 1'b0;
        end else if (advance && (gnt != 2'b00)) begin
            last_q <= gnt[1];
        end
    end

endmodule

// File: rtl/jedro_1_csr_access_ctrl.sv
// Sequences CSR file accesses: 3-state read-modify-write for CSR instructions,
// single-state writes for the trap unit, with round-robin arbitration in IDLE.
module jedro_1_csr_access_ctrl
    import jedro_1_csr_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 12
) (
    input  logic                  clk_i,
    input  logic                  rstn_i,
    input  logic                  instr_req_i,
    output logic                  instr_gnt_o,
    input  logic [2:0]            instr_op_i,
    input  logic [ADDR_WIDTH-1:0] instr_addr_i,
    input  logic [DATA_WIDTH-1:0] instr_operand_i,
    input  logic                  instr_src_zero_i,
    output logic                  instr_rvalid_o,
    output logic [DATA_WIDTH-1:0] instr_rdata_o,
    output logic                  instr_illegal_o,
    input  logic                  trap_req_i,
    output logic                  trap_gnt_o,
    input  logic [ADDR_WIDTH-1:0] trap_addr_i,
    input  logic [DATA_WIDTH-1:0] trap_wdata_i,
    input  logic                  flush_i,
    output logic [ADDR_WIDTH-1:0] csr_addr_o,
    output logic                  csr_we_o,
    output logic [DATA_WIDTH-1:0] csr_wdata_o,
    input  logic [DATA_WIDTH-1:0] csr_rdata_i,
    input  logic                  csr_exists_i,
    output logic [1:0]            dbg_state_o
);

    ctrl_state_e           state_q, state_d;
    csr_op_e               op_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] operand_q;
    logic                  src_zero_q;
    logic [DATA_WIDTH-1:0] old_q;
    logic                  illegal_q;
    logic                  wen_q;

    logic                  idle;
    logic [1:0]            arb_gnt;
    logic                  rd_wen;
    logic                  rd_illegal;
    logic [DATA_WIDTH-1:0] new_val;

    // Handshake: a requester holds req (and its fields) until it sees gnt high in the
    // same cycle; gnt is only raised in IDLE and the fields are captured on that edge.
    assign idle = (state_q == ST_IDLE);

    jedro_1_csr_rr_arb u_arb (
        .clk_i   (clk_i),
        .rstn_i  (rstn_i),
        .req     ({trap_req_i, instr_req_i} & {2{idle && rstn_i}}),
        .advance (idle),
        .gnt     (arb_gnt)
    );

    assign instr_gnt_o = arb_gnt[0];
    assign trap_gnt_o  = arb_gnt[1];
    assign dbg_state_o = state_q;

    assign rd_wen     = op_write_en(op_q, src_zero_q);
    assign rd_illegal = op_reserved(op_q) || !csr_exists_i ||
                        (rd_wen && (addr_q[ADDR_WIDTH-1 -: 2] == RO_PREFIX));

    always_comb begin
        new_val = operand_q;
        case (op_q)
            OP_RS, OP_RSI: new_val = old_q | operand_q;
            OP_RC, OP_RCI: new_val = old_q & ~operand_q;
            default:       new_val = operand_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q    <= ST_IDLE;
            op_q       <= OP_RSV0;
            addr_q     <= '0;
            operand_q  <= '0;
            src_zero_q <= 1'b0;
            old_q      <= '0;
            illegal_q  <= 1'b0;
            wen_q      <= 1'b0;
        end else begin
            state_q <= state_d;
            if (instr_gnt_o) begin
                op_q       <= csr_op_e'(instr_op_i);
                addr_q     <= instr_addr_i;
                operand_q  <= instr_operand_i;
                src_zero_q <= instr_src_zero_i;
            end else if (trap_gnt_o) begin
                addr_q    <= trap_addr_i;
                operand_q <= trap_wdata_i;
            end
            if (state_q == ST_READ) begin
                old_q     <= csr_rdata_i;
                illegal_q <= rd_illegal;
                wen_q     <= rd_wen;
            end
        end
    end

    always_comb begin
        state_d         = state_q;
        instr_rvalid_o  = 1'b0;
        instr_rdata_o   = '0;
        instr_illegal_o = 1'b0;
        csr_addr_o      = '0;
        csr_we_o        = 1'b0;
        csr_wdata_o     = '0;
        case (state_q)
            ST_IDLE: begin
                if (trap_gnt_o) begin
                    state_d = ST_TRAP_WR;
                end else if (instr_gnt_o) begin
                    state_d = ST_READ;
                end
            end
            ST_READ: begin
                csr_addr_o = addr_q;
                state_d    = flush_i ? ST_IDLE : ST_WRITE;
            end
            ST_WRITE: begin
                // Past READ the access commits; flush has no effect here.
                instr_rvalid_o  = 1'b1;
                instr_rdata_o   = old_q;
                instr_illegal_o = illegal_q;
                csr_addr_o      = addr_q;
                csr_wdata_o     = new_val;
                csr_we_o        = wen_q && !illegal_q;
                state_d         = ST_IDLE;
            end
            ST_TRAP_WR: begin
                csr_addr_o  = addr_q;
                csr_wdata_o = operand_q;
                csr_we_o    = csr_exists_i;
                state_d     = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_jedro_1_csr_access_ctrl.sv
// Directed bench for jedro_1_csr_access_ctrl with a small CSR file model around the DUT
// and a transaction-level reference model feeding expected queues.
module tb_jedro_1_csr_access_ctrl;

  localparam int DW = 32;
  localparam int AW = 12;

  logic          clk = 1'b0;
  logic          rstn_i = 1'b0;
  logic          instr_req_i = 1'b0;
  logic          instr_gnt_o;
  logic [2:0]    instr_op_i = '0;
  logic [AW-1:0] instr_addr_i = '0;
  logic [DW-1:0] instr_operand_i = '0;
  logic          instr_src_zero_i = 1'b0;
  logic          instr_rvalid_o;
  logic [DW-1:0] instr_rdata_o;
  logic          instr_illegal_o;
  logic          trap_req_i = 1'b0;
  logic          trap_gnt_o;
  logic [AW-1:0] trap_addr_i = '0;
  logic [DW-1:0] trap_wdata_i = '0;
  logic          flush_i = 1'b0;
  logic [AW-1:0] csr_addr_o;
  logic          csr_we_o;
  logic [DW-1:0] csr_wdata_o;
  logic [DW-1:0] csr_rdata_i;
  logic          csr_exists_i;
  logic [1:0]    dbg_state_o;

  int total = 0;
  int bad = 0;

  logic [DW-1:0]    exp_rd_q[$];
  logic             exp_ill_q[$];
  logic [AW+DW-1:0] exp_wr_q[$];

  logic [DW-1:0] env_mem[4];
  logic [DW-1:0] ref_mem[4];
  logic          bd_we = 1'b0;
  logic [1:0]    bd_idx = '0;
  logic [DW-1:0] bd_val = '0;
  bit            ref_last_trap = 1'b0;
  logic [DW-1:0] last_rdata = '0;
  logic          last_ill = 1'b0;
  logic [DW-1:0] mon_rd;
  logic          mon_ill;
  logic [AW+DW-1:0] mon_wr;

  jedro_1_csr_access_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk_i            (clk),
    .rstn_i           (rstn_i),
    .instr_req_i      (instr_req_i),
    .instr_gnt_o      (instr_gnt_o),
    .instr_op_i       (instr_op_i),
    .instr_addr_i     (instr_addr_i),
    .instr_operand_i  (instr_operand_i),
    .instr_src_zero_i (instr_src_zero_i),
    .instr_rvalid_o   (instr_rvalid_o),
    .instr_rdata_o    (instr_rdata_o),
    .instr_illegal_o  (instr_illegal_o),
    .trap_req_i       (trap_req_i),
    .trap_gnt_o       (trap_gnt_o),
    .trap_addr_i      (trap_addr_i),
    .trap_wdata_i     (trap_wdata_i),
    .flush_i          (flush_i),
    .csr_addr_o       (csr_addr_o),
    .csr_we_o         (csr_we_o),
    .csr_wdata_o      (csr_wdata_o),
    .csr_rdata_i      (csr_rdata_i),
    .csr_exists_i     (csr_exists_i),
    .dbg_state_o      (dbg_state_o)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- CSR file environment ----------------
  function automatic logic env_exists(input logic [AW-1:0] a);
    return (a == 12'h340) || (a == 12'h341) || (a == 12'h342) || (a == 12'hC00);
  endfunction

  function automatic logic [1:0] env_idx(input logic [AW-1:0] a);
    case (a)
      12'h341: return 2'd1;
      12'h342: return 2'd2;
      12'hC00: return 2'd3;
      default: return 2'd0;
    endcase
  endfunction

  always_comb begin
    csr_exists_i = env_exists(csr_addr_o);
    csr_rdata_i  = csr_exists_i ? env_mem[env_idx(csr_addr_o)] : '0;
  end

  always @(posedge clk) begin
    if (bd_we) env_mem[bd_idx] <= bd_val;
    else if (rstn_i && csr_we_o && env_exists(csr_addr_o)) env_mem[env_idx(csr_addr_o)] <= csr_wdata_o;
  end

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rstn_i) begin
      if (instr_rvalid_o) begin
        if (exp_rd_q.size() == 0) begin
          check("unexpected_rvalid", 1, 0);
        end else begin
          mon_rd  = exp_rd_q.pop_front();
          mon_ill = exp_ill_q.pop_front();
          check("rdata", instr_rdata_o, mon_rd);
          check("illegal", instr_illegal_o, mon_ill);
          last_rdata = instr_rdata_o;
          last_ill   = instr_illegal_o;
        end
      end
      if (csr_we_o) begin
        if (exp_wr_q.size() == 0) begin
          check("unexpected_write", {csr_addr_o, csr_wdata_o}, 0);
        end else begin
          mon_wr = exp_wr_q.pop_front();
          check("write_addr_data", {csr_addr_o, csr_wdata_o}, mon_wr);
        end
      end
    end
  end

  // ---------------- reference model ----------------
  task automatic instr_model(input logic [2:0] op, input logic [AW-1:0] addr,
                             input logic [DW-1:0] opnd, input logic sz, input bit flushed);
    logic          ex, wen, ill;
    logic [DW-1:0] old, nv;
    ex  = env_exists(addr);
    old = ex ? ref_mem[env_idx(addr)] : '0;
    wen = (op == 3'b001 || op == 3'b101) ? 1'b1 : !sz;
    ill = (op == 3'b000) || (op == 3'b100) || !ex || (wen && addr[11:10] == 2'b11);
    nv  = opnd;
    if (op == 3'b010 || op == 3'b110) nv = old | opnd;
    if (op == 3'b011 || op == 3'b111) nv = old & ~opnd;
    if (!flushed) begin
      exp_rd_q.push_back(old);
      exp_ill_q.push_back(ill);
      if (!ill && wen) begin
        exp_wr_q.push_back({addr, nv});
        ref_mem[env_idx(addr)] = nv;
      end
    end
  endtask

  task automatic trap_model(input logic [AW-1:0] addr, input logic [DW-1:0] data);
    if (env_exists(addr)) begin
      exp_wr_q.push_back({addr, data});
      ref_mem[env_idx(addr)] = data;
    end
  endtask

  // ---------------- drivers ----------------
  task automatic preload(input logic [AW-1:0] addr, input logic [DW-1:0] val);
    bd_idx = env_idx(addr);
    bd_val = val;
    bd_we  = 1'b1;
    ref_mem[env_idx(addr)] = val;
    @(posedge clk); #1;
    bd_we = 1'b0;
  endtask

  task automatic instr_set(input logic [2:0] op, input logic [AW-1:0] addr,
                           input logic [DW-1:0] opnd, input logic sz);
    instr_op_i       = op;
    instr_addr_i     = addr;
    instr_operand_i  = opnd;
    instr_src_zero_i = sz;
    instr_req_i      = 1'b1;
  endtask

  task automatic trap_set(input logic [AW-1:0] addr, input logic [DW-1:0] data);
    trap_addr_i  = addr;
    trap_wdata_i = data;
    trap_req_i   = 1'b1;
  endtask

  task automatic wait_gnt(input bit is_trap, input string name);
    bit got;
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clk);
      if (is_trap ? trap_gnt_o : instr_gnt_o) got = 1'b1;
    end
    check({name, "_gnt"}, got, 1);
    if (got) check({name, "_excl"}, is_trap ? instr_gnt_o : trap_gnt_o, 0);
    ref_last_trap = is_trap;
  endtask

  task automatic instr_tail(input logic [AW-1:0] addr, input bit fr, input bit fw);
    @(posedge clk); #1;
    instr_req_i = 1'b0;
    flush_i     = fr;
    @(negedge clk);
    check("read_no_rvalid", instr_rvalid_o, 0);
    check("read_addr", csr_addr_o, addr);
    check("read_no_gnt", {instr_gnt_o, trap_gnt_o}, 0);
    @(posedge clk); #1;
    flush_i = fw;
    @(negedge clk);
    check("write_rvalid", instr_rvalid_o, !fr);
    if (!fr) check("write_no_gnt", {instr_gnt_o, trap_gnt_o}, 0);
    @(posedge clk); #1;
    flush_i = 1'b0;
  endtask

  task automatic trap_tail(input logic [AW-1:0] addr);
    @(posedge clk); #1;
    trap_req_i = 1'b0;
    @(negedge clk);
    check("trap_we", csr_we_o, env_exists(addr));
    check("trap_no_gnt", {instr_gnt_o, trap_gnt_o}, 0);
    @(posedge clk); #1;
  endtask

  task automatic instr_access(input logic [2:0] op, input logic [AW-1:0] addr,
                              input logic [DW-1:0] opnd, input logic sz, input bit fr, input bit fw);
    instr_model(op, addr, opnd, sz, fr);
    instr_set(op, addr, opnd, sz);
    wait_gnt(1'b0, "instr");
    instr_tail(addr, fr, fw);
  endtask

  task automatic trap_access(input logic [AW-1:0] addr, input logic [DW-1:0] data);
    trap_model(addr, data);
    trap_set(addr, data);
    wait_gnt(1'b1, "trap");
    trap_tail(addr);
  endtask

  task automatic both_access(input bit exp_trap_first,
                             input logic [AW-1:0] taddr, input logic [DW-1:0] tdata,
                             input logic [2:0] op, input logic [AW-1:0] iaddr,
                             input logic [DW-1:0] opnd, input logic sz);
    bit win_trap;
    win_trap = !ref_last_trap;
    check("arb_model", win_trap, exp_trap_first);
    if (win_trap) begin
      trap_model(taddr, tdata);
      instr_model(op, iaddr, opnd, sz, 1'b0);
    end else begin
      instr_model(op, iaddr, opnd, sz, 1'b0);
      trap_model(taddr, tdata);
    end
    trap_set(taddr, tdata);
    instr_set(op, iaddr, opnd, sz);
    @(negedge clk);
    check("arb_trap_gnt", trap_gnt_o, win_trap);
    check("arb_instr_gnt", instr_gnt_o, !win_trap);
    ref_last_trap = win_trap;
    if (win_trap) begin
      trap_tail(taddr);
      wait_gnt(1'b0, "instr_second");
      instr_tail(iaddr, 1'b0, 1'b0);
    end else begin
      instr_tail(iaddr, 1'b0, 1'b0);
      wait_gnt(1'b1, "trap_second");
      trap_tail(taddr);
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    instr_req_i = 1'b1;
    trap_req_i  = 1'b1;
    #2;
    check("rst_gnt", {instr_gnt_o, trap_gnt_o}, 0);
    check("rst_outputs", {instr_rvalid_o, instr_illegal_o, csr_we_o}, 0);
    check("rst_data", {instr_rdata_o, csr_addr_o, csr_wdata_o}, 0);
    check("rst_state", dbg_state_o, 0);
    instr_req_i = 1'b0;
    trap_req_i  = 1'b0;
    preload(12'h340, 32'd3);
    preload(12'h341, 32'd0);
    preload(12'h342, 32'd0);
    preload(12'hC00, 32'h1234);
    @(negedge clk);
    rstn_i = 1'b1;
    @(posedge clk); #1;

    // 1: csrrwi mscratch
    instr_access(3'b101, 12'h340, 32'd6, 1'b0, 1'b0, 1'b0);
    check("t1_rdata_lit", last_rdata, 32'd3);
    check("t1_mscratch_lit", env_mem[0], 32'd6);

    // 2: set / clear / read-only set
    preload(12'h340, 32'hF0);
    instr_access(3'b010, 12'h340, 32'h0F, 1'b0, 1'b0, 1'b0);
    check("t2_rs_rdata_lit", last_rdata, 32'hF0);
    check("t2_rs_val_lit", env_mem[0], 32'hFF);
    instr_access(3'b011, 12'h340, 32'h0F, 1'b0, 1'b0, 1'b0);
    check("t2_rc_rdata_lit", last_rdata, 32'hFF);
    instr_access(3'b010, 12'h340, 32'h0F, 1'b1, 1'b0, 1'b0);
    check("t2_rs0_rdata_lit", last_rdata, 32'hF0);
    check("t2_rs0_val_lit", env_mem[0], 32'hF0);

    // 3: arbitration
    both_access(1'b1, 12'h342, 32'h0000_000B, 3'b010, 12'h342, 32'h100, 1'b0);
    check("t3_mcause_lit", env_mem[2], 32'h10B);
    both_access(1'b1, 12'h341, 32'h100, 3'b001, 12'h340, 32'hAA, 1'b0);
    trap_access(12'h341, 32'h200);
    both_access(1'b0, 12'h342, 32'h8000_000B, 3'b110, 12'h341, 32'h3, 1'b0);
    check("t3_mepc_lit", env_mem[1], 32'h203);
    trap_access(12'h7C0, 32'd5);

    // 4: illegal accesses
    instr_access(3'b001, 12'hC00, 32'd5, 1'b0, 1'b0, 1'b0);
    check("t4_ro_write_ill_lit", last_ill, 1'b1);
    instr_access(3'b010, 12'hC00, 32'd5, 1'b1, 1'b0, 1'b0);
    check("t4_ro_read_ill_lit", last_ill, 1'b0);
    check("t4_ro_read_data_lit", last_rdata, 32'h1234);
    instr_access(3'b001, 12'h7C0, 32'd5, 1'b0, 1'b0, 1'b0);
    check("t4_noexist_ill_lit", last_ill, 1'b1);
    instr_access(3'b100, 12'h340, 32'd5, 1'b0, 1'b0, 1'b0);
    check("t4_badop_ill_lit", last_ill, 1'b1);
    check("t4_mscratch_lit", env_mem[0], 32'hAA);

    // 5: flush
    instr_access(3'b001, 12'h340, 32'h55, 1'b0, 1'b1, 1'b0);
    check("t5_flush_state", dbg_state_o, 0);
    check("t5_flush_val_lit", env_mem[0], 32'hAA);
    instr_access(3'b001, 12'h340, 32'h77, 1'b0, 1'b0, 1'b0);
    instr_access(3'b101, 12'h341, 32'd9, 1'b0, 1'b0, 1'b1);
    check("t5_flush_write_lit", env_mem[1], 32'd9);

    // 6: reset during WRITE
    instr_set(3'b001, 12'h340, 32'hDEAD, 1'b0);
    wait_gnt(1'b0, "rst_instr");
    @(posedge clk); #1;
    instr_req_i = 1'b0;
    @(posedge clk); #1;
    check("t6_in_write", dbg_state_o, 2);
    rstn_i = 1'b0;
    instr_req_i = 1'b1;
    #1;
    check("t6_rst_outputs", {instr_rvalid_o, instr_illegal_o, csr_we_o, instr_gnt_o, trap_gnt_o}, 0);
    check("t6_rst_data", {instr_rdata_o, csr_addr_o, csr_wdata_o}, 0);
    check("t6_rst_state", dbg_state_o, 0);
    instr_req_i = 1'b0;
    ref_last_trap = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rstn_i = 1'b1;
    @(posedge clk); #1;
    check("t6_state_after", dbg_state_o, 0);
    check("t6_mscratch_lit", env_mem[0], 32'h77);
    both_access(1'b1, 12'h342, 32'h7, 3'b001, 12'h340, 32'h1, 1'b0);

    repeat (2) @(posedge clk);
    check("rd_queue_empty", exp_rd_q.size(), 0);
    check("wr_queue_empty", exp_wr_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
